// File: rtl/booth_sched.sv
// Round-robin scheduler sharing one 4x4 Booth multiplier between NREQ requesters.
// Optional RUN timeout is enabled by defining BOOTH_SCHED_TIMEOUT_EN.
//
// state | meaning
// IDLE  | multiplier held in reload; arbitrate pending requests
// LOAD  | winner operands presented with ready high
// RUN   | ready low; wait for count to reach ITER
// DONE  | one-cycle result strobe; advance round-robin pointer
module booth_sched #(
  parameter int NREQ = 4,
  parameter int ITER = 4,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] a_in,
  input  logic [4*NREQ-1:0] b_in,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic              done,
  output logic [IDW-1:0]    done_id,
  output logic [7:0]        product,
  output logic              err,
  output logic              mul_ready,
  output logic [3:0]        mul_inp1,
  output logic [3:0]        mul_inp2,
  input  logic [7:0]        mul_out,
  input  logic [3:0]        mul_count
);

  localparam int SUM_W = IDW + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   cur_id;
  logic [3:0]       op_a;
  logic [3:0]       op_b;

  logic [NREQ-1:0]  rot;
  logic             win_vld;
  logic [IDW-1:0]   win_off;
  logic [SUM_W-1:0] win_sum;
  logic [IDW-1:0]   win_id;
  logic [IDW-1:0]   next_ptr;
  logic             count_hit;

  // Rotating the request vector puts rr_ptr at bit 0, so the lowest set bit wins.
  assign rot = NREQ'({req, req} >> rr_ptr);

  always_comb begin
    win_vld = 1'b0;
    win_off = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        win_vld = 1'b1;
        win_off = IDW'(k);
      end
    end
    win_sum = {1'b0, rr_ptr} + {1'b0, win_off};
    if (win_sum >= SUM_W'(NREQ)) win_sum = win_sum - SUM_W'(NREQ);
  end

  assign win_id    = win_sum[IDW-1:0];
  assign next_ptr  = (cur_id == IDW'(NREQ - 1)) ? '0 : cur_id + IDW'(1);
  assign count_hit = (mul_count == 4'(ITER));
  assign mul_inp1  = op_a;
  assign mul_inp2  = op_b;

`ifdef BOOTH_SCHED_TIMEOUT_EN
  localparam int TMO_INIT = 2 * ITER + 2;
  localparam int TW = $clog2(TMO_INIT + 1);
  logic [TW-1:0] tmo_cnt;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      cur_id    <= '0;
      op_a      <= '0;
      op_b      <= '0;
      gnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      done_id   <= '0;
      product   <= '0;
      mul_ready <= 1'b1;
`ifdef BOOTH_SCHED_TIMEOUT_EN
      err       <= 1'b0;
      tmo_cnt   <= '0;
`endif
    end else begin
      gnt  <= '0;
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (win_vld) begin
            gnt    <= NREQ'(1) << win_id;
            op_a   <= a_in[{win_id, 2'b00} +: 4];
            op_b   <= b_in[{win_id, 2'b00} +: 4];
            cur_id <= win_id;
            busy   <= 1'b1;
            state  <= S_LOAD;
`ifdef BOOTH_SCHED_TIMEOUT_EN
            tmo_cnt <= TW'(TMO_INIT);
`endif
          end
        end
        S_LOAD: begin
          mul_ready <= 1'b0;
          state     <= S_RUN;
        end
        S_RUN: begin
          if (count_hit) begin
            product   <= mul_out;
            done_id   <= cur_id;
            done      <= 1'b1;
            mul_ready <= 1'b1;
            state     <= S_DONE;
`ifdef BOOTH_SCHED_TIMEOUT_EN
            err       <= 1'b0;
          end else if (tmo_cnt == TW'(1)) begin
            // count never arrived: report a zero product flagged as an error
            product   <= '0;
            done_id   <= cur_id;
            err       <= 1'b1;
            done      <= 1'b1;
            mul_ready <= 1'b1;
            state     <= S_DONE;
          end else begin
            tmo_cnt   <= tmo_cnt - TW'(1);
`endif
          end
        end
        S_DONE: begin
          rr_ptr <= next_ptr;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
